// File: rtl/rf_ctrl_pkg.sv
// rtl/rf_ctrl_pkg.sv - shared widths and FSM state type for the register-file access controller
package rf_ctrl_pkg;

    localparam int RF_NUM_REGS = 32;
    localparam int RF_ADDR_W   = 5;
    localparam int RF_DATA_W   = 64;

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } rf_ctrl_state_t;

endpackage

// File: rtl/rf_rr_arbiter.sv
// rtl/rf_rr_arbiter.sv - rotating-priority arbiter: first valid request at or after ptr wins
module rf_rr_arbiter #(
    parameter  int NUM_REQ = 2,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   idx,
    output logic               any
);

    int cand;

    always_comb begin
        gnt  = '0;
        idx  = '0;
        any  = 1'b0;
        cand = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = int'(ptr) + k;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            if (!any && req[cand]) begin
                any       = 1'b1;
                idx       = IDX_W'(cand);
                gnt[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rf_access_ctrl.sv
// rtl/rf_access_ctrl.sv - init sweep, shared read arbitration and writeback muxing for register_file
module rf_access_ctrl
    import rf_ctrl_pkg::*;
#(
    parameter  int                NUM_REGS   = RF_NUM_REGS,
    parameter  int                ADDR_W     = RF_ADDR_W,
    parameter  int                DATA_W     = RF_DATA_W,
    parameter  int                NUM_RD_REQ = 2,
    parameter  logic [DATA_W-1:0] INIT_VAL   = '0,
    localparam int                ID_W       = $clog2(NUM_RD_REQ)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_RD_REQ-1:0]        rd_req_valid,
    output logic [NUM_RD_REQ-1:0]        rd_req_ready,
    input  logic [NUM_RD_REQ*ADDR_W-1:0] rd_req_addr0,
    input  logic [NUM_RD_REQ*ADDR_W-1:0] rd_req_addr1,
    input  logic [NUM_RD_REQ*2-1:0]      rd_req_mask,
    output logic                         rd_rsp_valid,
    output logic [ID_W-1:0]              rd_rsp_id,
    output logic [DATA_W-1:0]            rd_rsp_data0,
    output logic [DATA_W-1:0]            rd_rsp_data1,
    input  logic                         wb0_valid,
    input  logic [ADDR_W-1:0]            wb0_addr,
    input  logic [DATA_W-1:0]            wb0_data,
    input  logic                         wb1_valid,
    output logic                         wb1_ready,
    input  logic [ADDR_W-1:0]            wb1_addr,
    input  logic [DATA_W-1:0]            wb1_data,
    output logic                         init_busy,
    output logic [1:0]                   rf_read_en,
    output logic [ADDR_W-1:0]            rf_raddr_0,
    output logic [ADDR_W-1:0]            rf_raddr_1,
    output logic                         rf_write_en,
    output logic [ADDR_W-1:0]            rf_waddr,
    output logic [DATA_W-1:0]            rf_wdata,
    input  logic [DATA_W-1:0]            rf_rdata_0,
    input  logic [DATA_W-1:0]            rf_rdata_1
);

    localparam logic [ADDR_W-1:0] LAST_REG = ADDR_W'(NUM_REGS - 1);
    localparam logic [ID_W-1:0]   LAST_REQ = ID_W'(NUM_RD_REQ - 1);

    rf_ctrl_state_t    state_q, state_d;
    logic [ADDR_W-1:0] init_cnt_q, init_cnt_d;
    logic [ID_W-1:0]   ptr_q, ptr_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
    logic [DATA_W-1:0] rsp_data0_q, rsp_data0_d;
    logic [DATA_W-1:0] rsp_data1_q, rsp_data1_d;

    logic                  run;
    logic [NUM_RD_REQ-1:0] arb_req, arb_gnt;
    logic [ID_W-1:0]       win_idx;
    logic                  win_any;
    logic [ADDR_W-1:0]     win_addr0, win_addr1;
    logic [1:0]            win_mask;
    logic                  wr_en;
    logic [ADDR_W-1:0]     wr_addr;
    logic [DATA_W-1:0]     wr_data;

    assign run       = !reset && (state_q == ST_RUN);
    assign init_busy = reset || (state_q == ST_INIT);
    assign arb_req   = run ? rd_req_valid : '0;

    rf_rr_arbiter #(.NUM_REQ(NUM_RD_REQ)) u_arb (
        .req (arb_req),
        .ptr (ptr_q),
        .gnt (arb_gnt),
        .idx (win_idx),
        .any (win_any)
    );

    assign win_addr0 = rd_req_addr0[int'(win_idx)*ADDR_W +: ADDR_W];
    assign win_addr1 = rd_req_addr1[int'(win_idx)*ADDR_W +: ADDR_W];
    assign win_mask  = rd_req_mask[int'(win_idx)*2 +: 2];

    assign rd_req_ready = arb_gnt;
    assign wb1_ready    = run && !wb0_valid;
    assign rf_read_en   = win_any ? win_mask : 2'b00;
    assign rf_raddr_0   = win_any ? win_addr0 : '0;
    assign rf_raddr_1   = win_any ? win_addr1 : '0;

    // Init sweep owns the write port; in RUN the ALU writeback beats the MEM one.
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        if (!reset) begin
            if (state_q == ST_INIT) begin
                wr_en   = 1'b1;
                wr_addr = init_cnt_q;
                wr_data = INIT_VAL;
            end else if (wb0_valid) begin
                wr_en   = 1'b1;
                wr_addr = wb0_addr;
                wr_data = wb0_data;
            end else if (wb1_valid) begin
                wr_en   = 1'b1;
                wr_addr = wb1_addr;
                wr_data = wb1_data;
            end
        end
    end

    assign rf_write_en = wr_en;
    assign rf_waddr    = wr_addr;
    assign rf_wdata    = wr_data;

    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        if (state_q == ST_INIT) begin
            init_cnt_d = init_cnt_q + 1'b1;
            if (init_cnt_q == LAST_REG) begin
                state_d    = ST_RUN;
                init_cnt_d = '0;
            end
        end
    end

    // A same-cycle write to a granted operand address wins over the stale array read.
    always_comb begin
        ptr_d       = ptr_q;
        rsp_valid_d = win_any;
        rsp_id_d    = win_any ? win_idx : '0;
        rsp_data0_d = '0;
        rsp_data1_d = '0;
        if (win_any) begin
            ptr_d = (win_idx == LAST_REQ) ? '0 : win_idx + 1'b1;
            if (win_mask[0]) begin
                rsp_data0_d = (wr_en && wr_addr == win_addr0) ? wr_data : rf_rdata_0;
            end
            if (win_mask[1]) begin
                rsp_data1_d = (wr_en && wr_addr == win_addr1) ? wr_data : rf_rdata_1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_INIT;
            init_cnt_q  <= '0;
            ptr_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_data0_q <= '0;
            rsp_data1_q <= '0;
        end else begin
            state_q     <= state_d;
            init_cnt_q  <= init_cnt_d;
            ptr_q       <= ptr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_data0_q <= rsp_data0_d;
            rsp_data1_q <= rsp_data1_d;
        end
    end

    assign rd_rsp_valid = rsp_valid_q;
    assign rd_rsp_id    = rsp_id_q;
    assign rd_rsp_data0 = rsp_data0_q;
    assign rd_rsp_data1 = rsp_data1_q;

endmodule
